// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - main control FSM for the multicycle MIPS datapath
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUOp,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC_R   = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        IMM_EX   = 4'd9,
        IMM_WB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    // State, latched opcode and retirement counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            op_q      <= 6'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and datapath controls; everything forced low while reset is held
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 3'b000;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    op_d    = opcode;
                    case (opcode)
                        OP_RTYPE:                         state_d = EXEC_R;
                        OP_LW, OP_SW:                     state_d = MEMADR;
                        OP_BEQ:                           state_d = BRANCH;
                        OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: state_d = IMM_EX;
                        OP_J:                             state_d = JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) state_d = MEMWB;
                end
                MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b010;
                    state_d = RTYPE_WB;
                end
                RTYPE_WB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 3'b110;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                    state_d     = FETCH;
                end
                IMM_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (op_q)
                        OP_ORI:  ALUOp = 3'b001;
                        OP_ANDI: ALUOp = 3'b011;
                        OP_SLTI: ALUOp = 3'b111;
                        default: ALUOp = 3'b000;
                    endcase
                    state_d = IMM_WB;
                end
                IMM_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
        retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed self-checking bench for multicycle_main_control
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic        instr_done, illegal_op;
    logic [31:0] retired;

    logic        w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
    logic        w_MemtoReg, w_RegDst, w_RegWrite, w_ALUSrcA;
    logic [1:0]  w_ALUSrcB, w_PCSource;
    logic [2:0]  w_ALUOp;
    logic [3:0]  w_state;
    logic        w_instr_done, w_illegal_op;
    logic [1:0]  w_retired;

    int total = 0;
    int bad   = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
        .retired(retired)
    );

    multicycle_main_control #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .MemRead(w_MemRead),
        .MemWrite(w_MemWrite), .IRWrite(w_IRWrite), .MemtoReg(w_MemtoReg), .RegDst(w_RegDst),
        .RegWrite(w_RegWrite), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .PCSource(w_PCSource),
        .ALUOp(w_ALUOp), .state(w_state), .instr_done(w_instr_done), .illegal_op(w_illegal_op),
        .retired(w_retired)
    );

    // one clock: inputs set before the call are taken at the posedge, outputs viewed at the negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b100011; mem_ready = 1'b1;
        tick();
        total++;
        if (state !== 4'd0 || MemRead !== 1'b0 || ALUSrcB !== 2'b00 || retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_hold state=%0d MemRead=%b ALUSrcB=%b retired=%0d want 0/0/00/0",
                     state, MemRead, ALUSrcB, retired);
        end
        rst_n = 1'b1;
        tick();  // FETCH -> DECODE
        tick();  // DECODE -> MEMADR
        mem_ready = 1'b0;
        tick();  // MEMADR -> MEMRD, held there
        total++;
        if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_memrd state=%0d MemRead=%b IorD=%b want 3/1/1", state, MemRead, IorD);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || MemRead !== 1'b0 || IorD !== 1'b0 || ALUSrcB !== 2'b00 ||
            ALUOp !== 3'b000 || instr_done !== 1'b0 || retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_async state=%0d MemRead=%b IorD=%b ALUSrcB=%b ALUOp=%b retired=%0d want all 0",
                     state, MemRead, IorD, ALUSrcB, ALUOp, retired);
        end
        exp_retired = 0;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        #1;
        total++;
        if (state !== 4'd0 || MemRead !== 1'b1 || ALUSrcB !== 2'b01 || ALUOp !== 3'b000 || IRWrite !== 1'b1) begin
            bad++;
            $display("FAIL reset_release state=%0d MemRead=%b ALUSrcB=%b ALUOp=%b IRWrite=%b want 0/1/01/000/1",
                     state, MemRead, ALUSrcB, ALUOp, IRWrite);
        end
    endtask

    task automatic test_rtype();
        opcode = 6'b000000; mem_ready = 1'b1;
        total++;
        if (state !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
            bad++;
            $display("FAIL rtype_fetch state=%0d PCWrite=%b IRWrite=%b want 0/1/1", state, PCWrite, IRWrite);
        end
        tick();
        total++;
        if (state !== 4'd1 || ALUSrcB !== 2'b11 || ALUOp !== 3'b000) begin
            bad++;
            $display("FAIL rtype_decode state=%0d ALUSrcB=%b ALUOp=%b want 1/11/000", state, ALUSrcB, ALUOp);
        end
        tick();
        total++;
        if (state !== 4'd6 || ALUOp !== 3'b010 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
            bad++;
            $display("FAIL rtype_exec state=%0d ALUOp=%b ALUSrcA=%b ALUSrcB=%b want 6/010/1/00",
                     state, ALUOp, ALUSrcA, ALUSrcB);
        end
        tick();
        total++;
        if (state !== 4'd7 || RegDst !== 1'b1 || RegWrite !== 1'b1 || MemtoReg !== 1'b0 || instr_done !== 1'b1) begin
            bad++;
            $display("FAIL rtype_wb state=%0d RegDst=%b RegWrite=%b MemtoReg=%b done=%b want 7/1/1/0/1",
                     state, RegDst, RegWrite, MemtoReg, instr_done);
        end
        exp_retired++;
        tick();
        total++;
        if (state !== 4'd0 || instr_done !== 1'b0 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL rtype_retire state=%0d done=%b retired=%0d want 0/0/%0d",
                     state, instr_done, retired, exp_retired);
        end
    endtask

    task automatic test_lw_wait();
        int cycles;
        opcode = 6'b100011; mem_ready = 1'b1;
        cycles = 0;
        tick(); cycles++;
        tick(); cycles++;
        total++;
        if (state !== 4'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUOp !== 3'b000) begin
            bad++;
            $display("FAIL lw_memadr state=%0d ALUSrcA=%b ALUSrcB=%b ALUOp=%b want 2/1/10/000",
                     state, ALUSrcA, ALUSrcB, ALUOp);
        end
        mem_ready = 1'b0;
        tick(); cycles++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1 || instr_done !== 1'b0) begin
                bad++;
                $display("FAIL lw_memrd_wait%0d state=%0d MemRead=%b IorD=%b done=%b want 3/1/1/0",
                         i, state, MemRead, IorD, instr_done);
            end
            tick(); cycles++;
        end
        mem_ready = 1'b1;
        tick(); cycles++;
        total++;
        if (state !== 4'd4 || MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0 || instr_done !== 1'b1) begin
            bad++;
            $display("FAIL lw_memwb state=%0d MemtoReg=%b RegWrite=%b RegDst=%b done=%b want 4/1/1/0/1",
                     state, MemtoReg, RegWrite, RegDst, instr_done);
        end
        exp_retired++;
        tick(); cycles++;
        total++;
        if (state !== 4'd0 || cycles !== 8 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL lw_total state=%0d cycles=%0d retired=%0d want 0/8/%0d",
                     state, cycles, retired, exp_retired);
        end
    endtask

    task automatic test_sw();
        opcode = 6'b101011; mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemRead !== 1'b1) begin
            bad++;
            $display("FAIL fetch_wait state=%0d IRWrite=%b PCWrite=%b MemRead=%b want 0/0/0/1",
                     state, IRWrite, PCWrite, MemRead);
        end
        tick();
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        total++;
        if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL sw_wait state=%0d MemWrite=%b IorD=%b done=%b want 5/1/1/0",
                     state, MemWrite, IorD, instr_done);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (instr_done !== 1'b1) begin
            bad++;
            $display("FAIL sw_done done=%b want 1", instr_done);
        end
        exp_retired++;
        tick();
        total++;
        if (state !== 4'd0 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL sw_retire state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
        end
    endtask

    task automatic test_imm();
        logic [5:0] ops  [4];
        logic [2:0] aops [4];
        ops  = '{6'b001101, 6'b001100, 6'b001010, 6'b001000};
        aops = '{3'b001,    3'b011,    3'b111,    3'b000};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            tick();
            tick();
            opcode = 6'b111111;  // op_q must hold the decoded opcode
            #1;
            total++;
            if (state !== 4'd9 || ALUOp !== aops[i] || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin
                bad++;
                $display("FAIL imm_ex%0d state=%0d ALUOp=%b ALUSrcA=%b ALUSrcB=%b want 9/%b/1/10",
                         i, state, ALUOp, ALUSrcA, ALUSrcB, aops[i]);
            end
            tick();
            total++;
            if (state !== 4'd10 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0 || instr_done !== 1'b1) begin
                bad++;
                $display("FAIL imm_wb%0d state=%0d RegWrite=%b RegDst=%b MemtoReg=%b done=%b want 10/1/0/0/1",
                         i, state, RegWrite, RegDst, MemtoReg, instr_done);
            end
            exp_retired++;
            tick();
        end
        total++;
        if (state !== 4'd0 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL imm_retired state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
        end
    endtask

    task automatic test_branch_jump();
        mem_ready = 1'b1;
        opcode = 6'b000100;
        tick();
        tick();
        total++;
        if (state !== 4'd8 || ALUOp !== 3'b110 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 ||
            ALUSrcA !== 1'b1 || PCWrite !== 1'b0 || instr_done !== 1'b1) begin
            bad++;
            $display("FAIL beq state=%0d ALUOp=%b PCWriteCond=%b PCSource=%b ALUSrcA=%b PCWrite=%b done=%b want 8/110/1/01/1/0/1",
                     state, ALUOp, PCWriteCond, PCSource, ALUSrcA, PCWrite, instr_done);
        end
        exp_retired++;
        tick();
        total++;
        if (state !== 4'd0 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL beq_len state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
        end
        opcode = 6'b000010;
        tick();
        tick();
        total++;
        if (state !== 4'd11 || PCWrite !== 1'b1 || PCSource !== 2'b10 || PCWriteCond !== 1'b0 || instr_done !== 1'b1) begin
            bad++;
            $display("FAIL jump state=%0d PCWrite=%b PCSource=%b PCWriteCond=%b done=%b want 11/1/10/0/1",
                     state, PCWrite, PCSource, PCWriteCond, instr_done);
        end
        exp_retired++;
        tick();
        total++;
        if (state !== 4'd0 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL jump_len state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
        end
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1;
        opcode = 6'b111111;
        tick();
        total++;
        if (state !== 4'd1 || illegal_op !== 1'b1 || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL illegal_decode state=%0d illegal_op=%b done=%b want 1/1/0", state, illegal_op, instr_done);
        end
        tick();
        total++;
        if (state !== 4'd0 || illegal_op !== 1'b0 || retired !== 32'(exp_retired)) begin
            bad++;
            $display("FAIL illegal_after state=%0d illegal_op=%b retired=%0d want 0/0/%0d",
                     state, illegal_op, retired, exp_retired);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            tick(); tick(); tick(); tick();
        end
        total++;
        if (w_retired !== 2'd1 || retired !== 32'd5 || w_state !== 4'd0) begin
            bad++;
            $display("FAIL wrap narrow=%0d wide=%0d state=%0d want 1/5/0", w_retired, retired, w_state);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_imm();
        test_branch_jump();
        test_illegal();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
